// File: rtl/systolic_skew_feeder_pkg.sv
// Shared constants, state encoding and drain-length helper for the skew feeder.
package systolic_skew_feeder_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Skew flush (n-1) plus propagation across the array (2n-1).
   function automatic int drain_len(input int array_size);
      return 3 * array_size - 2;
   endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew.sv
// Zero-reset shift register; output is the input delayed by DEPTH cycles.
module skew_delay_line #(
   parameter int DEPTH  = 1,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DEPTH-1:0][DATA_W-1:0] sr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr <= '0;
      end else begin
         sr[0] <= din;
         for (int s = 1; s < DEPTH; s++) sr[s] <= sr[s-1];
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Feeds the systolic array: diagonal skew of data/weight lanes plus tile drain sequencing.
module systolic_skew_feeder #(
   parameter int  ARRAY_SIZE = 4,
   parameter int  DATA_W     = systolic_skew_feeder_pkg::DATA_W,
   parameter int  MAX_K      = 255,
   localparam int CNT_W      = $clog2(MAX_K + 1),
   localparam int BUS_W      = DATA_W * ARRAY_SIZE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BUS_W-1:0] in_data,
   input  logic [BUS_W-1:0] in_weight,
   input  logic             in_last,
   output logic [BUS_W-1:0] datain,
   output logic [BUS_W-1:0] weightin,
   output logic             tile_start,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] beat_count,
   output logic             overflow
);

   import systolic_skew_feeder_pkg::*;

   localparam int DRAIN_LEN = drain_len(ARRAY_SIZE);
   localparam int DCW       = $clog2(DRAIN_LEN + 1);

   state_t         state, state_nxt;
   logic [DCW-1:0] drain_cnt;
   logic           xfer;

   logic [ARRAY_SIZE-1:0][DATA_W-1:0] pipe_d, pipe_w, skew_d, skew_w;

   // Ready is gated by reset directly so it reads 0 while reset is held.
   assign in_ready = reset && ((state == IDLE) || (state == STREAM));
   assign xfer     = in_valid && in_ready;
   assign busy     = (state == STREAM) || (state == DRAIN);
   assign done     = (state == DONE);

   // Bubbles, drain and idle all push zeros so the array accumulators hold.
   assign pipe_d = xfer ? in_data   : '0;
   assign pipe_w = xfer ? in_weight : '0;

   for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
      skew_delay_line #(.DEPTH(i + 1), .DATA_W(DATA_W)) u_skew_d (
         .clk  (clk),
         .reset(reset),
         .din  (pipe_d[i]),
         .dout (skew_d[i])
      );
      skew_delay_line #(.DEPTH(i + 1), .DATA_W(DATA_W)) u_skew_w (
         .clk  (clk),
         .reset(reset),
         .din  (pipe_w[i]),
         .dout (skew_w[i])
      );
   end

   assign datain   = skew_d;
   assign weightin = skew_w;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (xfer) state_nxt = in_last ? DRAIN : STREAM;
         STREAM:  if (xfer && in_last) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         drain_cnt  <= '0;
         tile_start <= 1'b0;
         beat_count <= '0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nxt;
         tile_start <= xfer && (state == IDLE);

         if (state != DRAIN && state_nxt == DRAIN)
            drain_cnt <= DCW'(DRAIN_LEN - 1);
         else if (state == DRAIN && drain_cnt != '0)
            drain_cnt <= drain_cnt - 1'b1;

         // First beat restarts the count; beats beyond MAX_K are still forwarded.
         if (xfer && state == IDLE) begin
            beat_count <= CNT_W'(1);
         end else if (xfer && state == STREAM) begin
            if (beat_count == CNT_W'(MAX_K)) overflow <= 1'b1;
            else                             beat_count <= beat_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Random and directed stimulus against a timeline-level model of the skew feeder.
module tb_systolic_skew_feeder;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int BW = N * W;
   localparam int DL = 3 * N - 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid, in_last;
   logic [BW-1:0] in_data, in_weight;
   logic          in_ready, in_ready_s;
   logic [BW-1:0] datain, weightin, datain_s, weightin_s;
   logic          tile_start, busy, done, overflow;
   logic          tile_start_s, busy_s, done_s, overflow_s;
   logic [7:0]    beat_count;
   logic [1:0]    beat_count_s;

   always #5 clk = ~clk;

   systolic_skew_feeder #(.ARRAY_SIZE(N), .DATA_W(W), .MAX_K(255)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
      .datain(datain), .weightin(weightin), .tile_start(tile_start),
      .busy(busy), .done(done), .beat_count(beat_count), .overflow(overflow)
   );

   systolic_skew_feeder #(.ARRAY_SIZE(N), .DATA_W(W), .MAX_K(3)) u_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
      .datain(datain_s), .weightin(weightin_s), .tile_start(tile_start_s),
      .busy(busy_s), .done(done_s), .beat_count(beat_count_s), .overflow(overflow_s)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: history of pipeline inputs (newest first) and a tile timeline.
   logic [BW-1:0] hd[$], hw[$];
   bit            in_tile;
   int            since_last;   // edges since last beat: 1..DL drain, DL+1 done, -1 none
   int            cnt_a, cnt_b;
   bit            ovf_a, ovf_b, ts_exp;

   task automatic model_reset();
      hd.delete(); hw.delete();
      for (int i = 0; i < N; i++) begin hd.push_back('0); hw.push_back('0); end
      in_tile = 0; since_last = -1;
      cnt_a = 0; cnt_b = 0; ovf_a = 0; ovf_b = 0; ts_exp = 0;
   endtask

   task automatic compare_all();
      logic [BW-1:0] ed, ew, td, tw;
      bit            drain_now;
      ed = '0; ew = '0;
      for (int i = 0; i < N; i++) begin
         td = hd[i]; tw = hw[i];
         ed[i*W +: W] = td[i*W +: W];
         ew[i*W +: W] = tw[i*W +: W];
      end
      drain_now = (since_last >= 1) && (since_last <= DL);
      chk("datain",     32'(datain),     32'(ed));
      chk("weightin",   32'(weightin),   32'(ew));
      chk("datain_s",   32'(datain_s),   32'(ed));
      chk("weightin_s", 32'(weightin_s), 32'(ew));
      chk("tile_start", 32'(tile_start), 32'(ts_exp));
      chk("busy",       32'(busy),       32'(in_tile || drain_now));
      chk("done",       32'(done),       32'(since_last == DL + 1));
      chk("done_s",     32'(done_s),     32'(since_last == DL + 1));
      chk("beat_count", 32'(beat_count), 32'(cnt_a));
      chk("beat_cnt_s", 32'(beat_count_s), 32'(cnt_b));
      chk("overflow",   32'(overflow),   32'(ovf_a));
      chk("overflow_s", 32'(overflow_s), 32'(ovf_b));
   endtask

   // Called just after an edge; drives one beat and checks the following edge.
   task automatic cyc(input bit v, input bit l, input logic [BW-1:0] d, input logic [BW-1:0] wv);
      bit rdy, xf, first;
      in_valid = v; in_last = l; in_data = d; in_weight = wv;
      rdy = (since_last < 0);
      #1;
      chk("in_ready",   32'(in_ready),   32'(rdy));
      chk("in_ready_s", 32'(in_ready_s), 32'(rdy));
      xf    = v && rdy;
      first = xf && !in_tile;
      @(posedge clk); #1;
      hd.push_front(xf ? d : '0);  void'(hd.pop_back());
      hw.push_front(xf ? wv : '0); void'(hw.pop_back());
      if (since_last >= 0) since_last++;
      if (since_last > DL + 1) since_last = -1;
      ts_exp = first;
      if (first) begin
         cnt_a = 1; cnt_b = 1;
      end else if (xf) begin
         if (cnt_a == 255) ovf_a = 1; else cnt_a++;
         if (cnt_b == 3)   ovf_b = 1; else cnt_b++;
      end
      if (xf && l) begin in_tile = 0; since_last = 1; end
      else if (first) in_tile = 1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, $urandom, $urandom);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_datain"},   32'(datain),     32'd0);
      chk({tag, "_weightin"}, 32'(weightin),   32'd0);
      chk({tag, "_ready"},    32'(in_ready),   32'd0);
      chk({tag, "_busy"},     32'(busy),       32'd0);
      chk({tag, "_done"},     32'(done),       32'd0);
      chk({tag, "_tstart"},   32'(tile_start), 32'd0);
      chk({tag, "_count"},    32'(beat_count), 32'd0);
      chk({tag, "_ovf"},      32'(overflow_s), 32'd0);
   endtask

   initial begin
      reset = 1'b0; in_valid = 0; in_last = 0; in_data = '0; in_weight = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      reset = 1'b1;
      #1;
      chk("rst_release_ready", 32'(in_ready), 32'd1);

      // Single-beat tile straight into drain.
      cyc(1, 1, 32'h04030201, 32'h08070605);
      idle(DL + 3);

      // Streaming with one bubble.
      cyc(1, 0, 32'hA3A2A1A0, 32'h13121110);
      cyc(1, 0, 32'hB3B2B1B0, 32'h23222120);
      cyc(0, 0, $urandom, $urandom);
      cyc(1, 1, 32'hC3C2C1C0, 32'h33323130);
      idle(DL + 3);

      // Valid held high through drain and done.
      cyc(1, 0, $urandom, $urandom);
      cyc(1, 1, $urandom, $urandom);
      for (int k = 0; k < DL + 4; k++) cyc(1, 0, $urandom, $urandom);
      cyc(1, 1, $urandom, $urandom);
      idle(DL + 3);

      // Saturation of the MAX_K=3 instance.
      for (int k = 0; k < 5; k++) cyc(1, (k == 4), $urandom, $urandom);
      idle(DL + 3);

      // Reset mid-tile abandons the tile.
      for (int k = 0; k < 3; k++) cyc(1, 0, $urandom, $urandom);
      reset = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("midrst_hold");
      reset = 1'b1;
      model_reset();
      #1;
      chk("midrst_release_ready", 32'(in_ready), 32'd1);
      idle(DL + 3);

      // Random traffic.
      for (int k = 0; k < 600; k++)
         cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, $urandom, $urandom);
      idle(DL + 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
